// File: rtl/fft_result_readout_seq.sv
// Readout sequencer for the FFT result mux: steps mux_sel through one frame in linear or
// bit-reversed order, captures each selected word and streams it out over valid/ready.
module fft_result_readout_seq #(
    parameter int DATA_LENGTH = 8,
    parameter int NUM_WORDS   = 64,
    parameter int SEL_WIDTH   = 7,
    parameter int BITREV      = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    output logic [SEL_WIDTH-1:0]   mux_sel,
    input  logic [DATA_LENGTH-1:0] mux_data,
    output logic [DATA_LENGTH-1:0] out_data,
    output logic [5:0]             out_index,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);

    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_OUT,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [SEL_WIDTH-1:0]   sel_q, sel_d;
    logic [DATA_LENGTH-1:0] data_q, data_d;
    logic [5:0]             index_q, index_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;

    // Mux select for a linear word index: identity, or bit-reversed within IDX_W bits.
    function automatic logic [SEL_WIDTH-1:0] sel_of(input logic [IDX_W-1:0] i);
        logic [IDX_W-1:0] r;
        r = i;
        if (BITREV != 0) begin
            for (int b = 0; b < IDX_W; b++) r[b] = i[IDX_W-1-b];
        end
        return SEL_WIDTH'(r);
    endfunction

    always_comb begin
        // NOTE: every signal assigned here gets a hold default first, so no path can infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        data_d  = data_q;
        index_d = index_q;
        valid_d = valid_q;
        last_d  = last_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    sel_d   = sel_of('0);
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    data_d  = mux_data;
                    index_d = 6'(idx_q);
                    valid_d = 1'b1;
                    last_d  = (idx_q == IDX_MAX);
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                // Abort wins over a handshake arriving in the same cycle.
                if (abort) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (idx_q == IDX_MAX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        sel_d   = sel_of(idx_q + 1'b1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments and clear asynchronously on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            index_q <= index_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign mux_sel   = sel_q;
    assign out_data  = data_q;
    assign out_index = index_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign busy      = (state_q == S_LOAD) || (state_q == S_OUT);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_fft_result_readout_seq.sv
// Bench for fft_result_readout_seq: three configurations (64 linear, 64 bit-reversed,
// 16 bit-reversed) driven with directed and random backpressure against a word-order model.
module tb_fft_result_readout_seq;

    logic       clk;
    logic       rst;
    logic       start  [3];
    logic       abort  [3];
    logic       ready  [3];
    logic [6:0] sel    [3];
    logic [7:0] mdata  [3];
    logic [7:0] odata  [3];
    logic [5:0] oindex [3];
    logic       valid  [3];
    logic       last   [3];
    logic       busy   [3];
    logic       done   [3];
    logic [7:0] tbl    [16];

    int vectors;
    int miscompares;
    int cyc;

    fft_result_readout_seq #(.DATA_LENGTH(8), .NUM_WORDS(64), .SEL_WIDTH(7), .BITREV(0)) dut_lin (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .mux_sel(sel[0]),
        .mux_data(mdata[0]), .out_data(odata[0]), .out_index(oindex[0]), .out_valid(valid[0]),
        .out_ready(ready[0]), .out_last(last[0]), .busy(busy[0]), .done(done[0]));

    fft_result_readout_seq #(.DATA_LENGTH(8), .NUM_WORDS(64), .SEL_WIDTH(7), .BITREV(1)) dut_rev64 (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .mux_sel(sel[1]),
        .mux_data(mdata[1]), .out_data(odata[1]), .out_index(oindex[1]), .out_valid(valid[1]),
        .out_ready(ready[1]), .out_last(last[1]), .busy(busy[1]), .done(done[1]));

    fft_result_readout_seq #(.DATA_LENGTH(8), .NUM_WORDS(16), .SEL_WIDTH(7), .BITREV(1)) dut_rev16 (
        .clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]), .mux_sel(sel[2]),
        .mux_data(mdata[2]), .out_data(odata[2]), .out_index(oindex[2]), .out_valid(valid[2]),
        .out_ready(ready[2]), .out_last(last[2]), .busy(busy[2]), .done(done[2]));

    // Result mux models: k -> 0x40+k, k -> k, and a random 16-entry table.
    assign mdata[0] = 8'h40 + {2'b00, sel[0][5:0]};
    assign mdata[1] = {2'b00, sel[1][5:0]};
    assign mdata[2] = tbl[sel[2][3:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rev(input int k, input int bits);
        int r;
        r = 0;
        for (int b = 0; b < bits; b++) begin
            if (((k >> b) & 1) != 0) r += 1 << (bits - 1 - b);
        end
        return r;
    endfunction

    function automatic int exp_sel(input int d, input int k);
        if (d == 0) return k;
        if (d == 1) return rev(k, 6);
        return rev(k, 4);
    endfunction

    function automatic int exp_data(input int d, input int k);
        if (d == 0) return 'h40 + k;
        if (d == 1) return rev(k, 6);
        return int'(tbl[rev(k, 4)]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Runs one frame on DUT d, starting and ending on a falling edge. hold >= 0 stalls
    // that word for 5 cycles; rnd randomises out_ready.
    task automatic run_frame(input int d, input int n, input bit rnd, input int hold);
        int k, stall, since, budget, e_cnt;
        bit seen;
        logic [7:0] held_data;
        logic [6:0] held_sel;
        logic [5:0] held_index;
        k = 0; stall = 0; budget = 0; seen = 1'b0;
        held_data = '0; held_sel = '0; held_index = '0;
        start[d] = 1'b1;
        e_cnt = cyc + 1;
        @(negedge clk);
        start[d] = 1'b0;
        since = 1;
        while (k < n && budget < 40 * n) begin
            if (k == hold && stall < 5) ready[d] = 1'b0;
            else if (rnd)              ready[d] = ($urandom_range(0, 3) != 0);
            else                       ready[d] = 1'b1;
            if (seen) check("valid_held", valid[d], 1);
            if (valid[d]) begin
                if (!seen) begin
                    seen = 1'b1;
                    check("word_latency", since, 2);
                    held_data = odata[d]; held_sel = sel[d]; held_index = oindex[d];
                end else begin
                    check("hold_data", odata[d], held_data);
                    check("hold_sel", sel[d], held_sel);
                    check("hold_index", oindex[d], held_index);
                end
                if (ready[d]) begin
                    check("out_index", oindex[d], k);
                    check("out_data", odata[d], exp_data(d, k));
                    check("out_last", last[d], (k == n - 1));
                    check("mux_sel", sel[d], exp_sel(d, k));
                    check("sel_in_range", (sel[d] < n), 1);
                    check("busy_mid", busy[d], 1);
                    check("done_mid", done[d], 0);
                    k++;
                    since = 0;
                    seen = 1'b0;
                end else if (k == hold) begin
                    stall++;
                end
            end
            @(negedge clk);
            since++;
            budget++;
        end
        check("frame_words", k, n);
        check("done_pulse", done[d], 1);
        check("busy_in_done", busy[d], 0);
        check("valid_in_done", valid[d], 0);
        check("last_in_done", last[d], 0);
        if (!rnd && hold < 0) check("frame_cycles", cyc - e_cnt, 2 * n);
        ready[d] = 1'b0;
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        check("done_one_cycle", done[d], 0);
        check("start_in_done_ignored", busy[d], 0);
        @(negedge clk);
        check("idle_after_done", busy[d], 0);
    endtask

    initial begin
        int k, budget;
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 16; i++) tbl[i] = 8'($urandom_range(1, 255));
        for (int d = 0; d < 3; d++) begin
            start[d] = 1'b0; abort[d] = 1'b0; ready[d] = 1'b0;
        end
        rst = 1'b1;
        #12;
        for (int d = 0; d < 3; d++) begin
            check("rst_sel", sel[d], 0);
            check("rst_valid", valid[d], 0);
            check("rst_busy_done", {busy[d], done[d], last[d]}, 0);
            check("rst_data_index", {odata[d], oindex[d]}, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Linear frame with out_ready held high, then with a 5-cycle stall at word 10.
        run_frame(0, 64, 1'b0, -1);
        run_frame(0, 64, 1'b0, 10);

        // Abort at word 20 with an extra start pulsed at word 5.
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        ready[0] = 1'b1;
        k = 0; budget = 0;
        while (budget < 200) begin
            start[0] = 1'b0;
            if (valid[0]) begin
                check("abort_seq_index", oindex[0], k);
                if (k == 20) break;
                if (k == 5) start[0] = 1'b1;
                k++;
            end
            @(negedge clk);
            budget++;
        end
        check("abort_reached_20", k, 20);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        ready[0] = 1'b0;
        check("abort_valid", valid[0], 0);
        check("abort_busy", busy[0], 0);
        check("abort_no_done", done[0], 0);
        @(negedge clk);
        check("abort_idle_busy", busy[0], 0);
        check("abort_idle_done", done[0], 0);
        run_frame(0, 64, 1'b0, -1);

        // Bit-reversed 64-word frames, steady and with random backpressure.
        run_frame(1, 64, 1'b0, -1);
        run_frame(1, 64, 1'b1, -1);

        // Asynchronous reset while word 4 waits in OUT.
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        ready[1] = 1'b1;
        for (int i = 0; i < 8; i++) @(negedge clk);
        ready[1] = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("pre_rst_valid", valid[1], 1);
        check("pre_rst_index", oindex[1], 4);
        #2 rst = 1'b1;
        #1;
        check("async_rst_sel", sel[1], 0);
        check("async_rst_data", odata[1], 0);
        check("async_rst_index", oindex[1], 0);
        check("async_rst_flags", {valid[1], last[1], busy[1], done[1]}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_idle", {valid[1], busy[1], done[1]}, 0);
        end

        // 16-word bit-reversed frames over a random table.
        run_frame(2, 16, 1'b1, -1);
        run_frame(2, 16, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
